stream_fold_sink: RTL
=====================

# stream_fold_sink

Downstream consumer stage for a handshaked element stream. Each beat carries a 64-bit element in `field0` and an end-of-stream flag in `field1`. The block folds every stream into a signed sum and an element count. On EOS it presents the result on a second valid/ready channel, then clears itself and accepts the next stream. It sits directly after a stream-producing top-level output port and replaces bench-side `$display` checking with synthesizable result capture.

## Interface
- `DATA_WIDTH`, 64: element width and sum width (two's complement).
- `COUNT_WIDTH`, 32: element counter width.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block accepts a beat; registered.
- `in_data_field0`  in  DATA_WIDTH  element value.
- `in_data_field1`  in  1  1 = EOS beat; `field0` is ignored on EOS.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumer ready.
- `res_sum`  out  DATA_WIDTH  signed sum of the stream's elements.
- `res_count`  out  COUNT_WIDTH  number of non-EOS elements, saturating.
- `res_overflow`  out  1  sticky signed-overflow flag (see Configuration).
- `done`  out  1  one-cycle pulse after each result handshake.

## Operation
- The state machine has three states: INIT, ACCUM, EMIT.
- INIT (reset state):
  - `in_ready` = 0, `res_valid` = 0.
  - Moves to ACCUM on the first clock edge after `reset` deasserts.
- ACCUM:
  - `in_ready` = 1, `res_valid` = 0.
  - On `in_valid && in_ready` with `field1` = 0:
    - sum <= sum + `field0`, wrapping modulo 2^DATA_WIDTH.
    - count <= count + 1, saturating at 2^COUNT_WIDTH-1.
  - On a handshake with `field1` = 1: the accumulators hold, and the block moves to EMIT.
- EMIT:
  - `in_ready` = 0, `res_valid` = 1.
  - `res_sum`, `res_count` and `res_overflow` are driven from registers and held stable.
  - `in_valid` is ignored.
  - On `res_valid && res_ready`: sum, count and overflow clear to 0, `done` <= 1, and the block moves to ACCUM.
- `done` is 0 in every other cycle.
- The result outputs always reflect the accumulator registers. Consumers sample them only while `res_valid` = 1.
- A stream consisting of EOS only produces sum = 0, count = 0, overflow = 0.
- Reset asserted mid-stream or during EMIT:
  - All registers clear immediately and the block enters INIT.
  - The partial result is discarded and is never emitted.

## Timing
- Reset values: `in_ready` 0, `res_valid` 0, `res_sum` 0, `res_count` 0, `res_overflow` 0, `done` 0.
- Throughput is one element per cycle in ACCUM.
- EOS accepted at edge N: `res_valid` = 1 and `in_ready` = 0 from N+1.
- Result handshake at edge M: `in_ready` = 1, accumulators = 0 and `done` = 1 from M+1. `done` returns to 0 at M+2.
- Minimum spacing from EOS acceptance to the next element acceptance is 2 cycles when `res_ready` is held at 1.
- `in_ready` and `res_valid` never depend combinationally on `in_valid` or `res_ready`.

## Configuration
- Macro: `STREAM_FOLD_OVERFLOW_EN`.
- Defined:
  - Each accepted element sets the overflow register if the two addends share a sign bit and the wrapped sum's sign differs from it.
  - The flag is sticky until the result handshake and drives `res_overflow`.
- Undefined:
  - No overflow logic is built; `res_overflow` is tied to 0.
- In both cases the sum wraps, and all other behaviour is identical.

## Test plan
- Reset 2 cycles, then stream 1, 2, 3, EOS with `res_ready` = 1:
  - `res_valid` is high exactly one cycle after EOS acceptance.
  - sum = 6, count = 3.
  - `done` pulses for one cycle, then `in_ready` = 1.
- EOS-only stream -> sum = 0, count = 0, overflow = 0.
- Stream 5, EOS, then hold `res_ready` = 0 for 5 cycles while `in_valid` = 1:
  - `res_valid` stays 1 and `in_ready` stays 0.
  - sum stays 5; no beats are consumed.
  - Raise `res_ready` -> handshake, `done` pulses.
- Back-to-back streams 10, EOS, -4, -6, EOS:
  - First result: sum = 10, count = 1.
  - Second result: sum = 0xFFFFFFFFFFFFFFF6, count = 2.
  - The accumulator is cleared between the two streams.
- Stream 0x7FFFFFFFFFFFFFFF, 1, EOS:
  - sum = 0x8000000000000000, count = 2.
  - `res_overflow` = 1 with `STREAM_FOLD_OVERFLOW_EN`, 0 without.
- Stream 7, 8, then assert `reset` mid-stream for one cycle:
  - Outputs drop to reset values immediately and `in_ready` = 0 during reset.
  - Then stream 2, EOS -> sum = 2, count = 1.

Source files
------------

// File: rtl/stream_fold_sink.sv
// stream_fold_sink: folds a handshaked element stream into a signed sum and a
// saturating element count, then presents the result on a valid/ready channel.
// Optional feature macro: STREAM_FOLD_OVERFLOW_EN (sticky signed-overflow flag).
module stream_fold_sink #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data_field0,
  input  logic                   in_data_field1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_sum,
  output logic [COUNT_WIDTH-1:0] res_count,
  output logic                   res_overflow,
  output logic                   done
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  sum_next;
  logic [DATA_WIDTH-1:0]  add_sum;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   done_next;
  logic                   take_elem;
  logic                   take_result;

  // Wrapped sum of the accumulator and the incoming element.
  assign add_sum     = res_sum + in_data_field0;
  assign take_elem   = (state == ACCUM) && in_valid && in_ready && !in_data_field1;
  assign take_result = (state == EMIT) && res_valid && res_ready;

  // Next-state and accumulator update logic.
  always_comb begin
    state_next = state;
    sum_next   = res_sum;
    count_next = res_count;
    done_next  = 1'b0;
    case (state)
      INIT: state_next = ACCUM;
      ACCUM: begin
        if (in_valid && in_ready) begin
          if (in_data_field1) begin
            state_next = EMIT;
          end else begin
            sum_next   = add_sum;
            count_next = (&res_count) ? res_count : res_count + COUNT_WIDTH'(1);
          end
        end
      end
      EMIT: begin
        if (take_result) begin
          state_next = ACCUM;
          sum_next   = '0;
          count_next = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase
  end

  // State, accumulators and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      res_sum   <= '0;
      res_count <= '0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      res_sum   <= sum_next;
      res_count <= count_next;
      done      <= done_next;
      in_ready  <= (state_next == ACCUM);
      res_valid <= (state_next == EMIT);
    end
  end

`ifdef STREAM_FOLD_OVERFLOW_EN
  logic ovf_next;

  // Sticky overflow: same-sign addends whose wrapped sum flips sign.
  always_comb begin
    ovf_next = res_overflow;
    if (take_elem) begin
      if ((res_sum[MSB] == in_data_field0[MSB]) && (add_sum[MSB] != res_sum[MSB])) begin
        ovf_next = 1'b1;
      end
    end else if (take_result) begin
      ovf_next = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_overflow <= 1'b0;
    end else begin
      res_overflow <= ovf_next;
    end
  end
`else
  assign res_overflow = 1'b0;
`endif

endmodule
